apb_req_master: RTL

//  APB initiator: turns a core-side req/gnt/rvalid request bus into single APB3

---
 rtl/apb_req_master.sv | 128 ++++++++++++
 1 files changed

// File: rtl/apb_req_master.sv
// APB3 initiator: converts a core req/gnt/rvalid request into single SETUP->ACCESS
// transfers, with an optional PREADY timeout that aborts a hung transfer with an error.
module apb_req_master #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT        = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_rvalid;
  logic                      r_err;
  logic [APB_DATA_WIDTH-1:0] r_rdata;
  logic                      r_pwrite;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic                      w_accept;
  logic                      w_done;
  logic                      w_abort;

  // Counter saturates rather than wraps; it never needs to exceed TIMEOUT.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign w_accept = (r_state == S_IDLE) && req_i;
  assign w_done   = (r_state == S_ACCESS) && pready_i;
  assign w_abort  = (TIMEOUT > 0) && (r_state == S_ACCESS) && !pready_i &&
                    (r_cnt == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (req_i) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_done || w_abort) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_o     = 1'b0;
    psel_o    = 1'b0;
    penable_o = 1'b0;
    case (r_state)
      S_IDLE:   gnt_o = 1'b1;
      S_SETUP:  psel_o = 1'b1;
      S_ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Request capture, wait counter and response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else begin
      r_rvalid <= w_done || w_abort;
      if (w_accept) begin
        r_pwrite <= we_i;
        r_paddr  <= addr_i;
        r_pwdata <= we_i ? wdata_i : '0;
        r_cnt    <= '0;
      end else if (r_state == S_ACCESS) begin
        r_cnt <= sat_inc(r_cnt);
      end
      if (w_done) begin
        r_rdata <= r_pwrite ? '0 : prdata_i;
        r_err   <= pslverr_i;
      end else if (w_abort) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;
  assign pwrite_o = r_pwrite;
  assign paddr_o  = r_paddr;
  assign pwdata_o = r_pwdata;

endmodule
